// File: rtl/hs4_pkg.sv
// Shared types and constants for the hs4_stage_fifo handshake buffer.
// FSM states are plain localparam codes so older tools and checkers can bind to them.
package hs4_pkg;

    localparam int SYNC_STAGES = 2;

    typedef logic [0:0] in_state_t;
    localparam in_state_t IN_IDLE = 1'b0;
    localparam in_state_t IN_ACK  = 1'b1;

    typedef logic [1:0] out_state_t;
    localparam out_state_t OUT_IDLE  = 2'd0;
    localparam out_state_t OUT_SETUP = 2'd1;
    localparam out_state_t OUT_REQ   = 2'd2;
    localparam out_state_t OUT_RTZ   = 2'd3;

    // Both FSM state registers live in one struct so a checker can bind to a single signal.
    typedef struct packed {
        in_state_t  in_state;
        out_state_t out_state;
    } hs4_fsm_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hs4_sync2.sv
// Two-flop synchroniser with synchronous active-high reset to 0.
// Used on req_in and ack_out when HS4_SYNC_EN is defined.
module hs4_sync2
    import hs4_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/hs4_stage_fifo.sv
// Elastic 4-phase req/ack stage: buffers up to DEPTH words between two handshake channels.
// Optional macro HS4_SYNC_EN inserts 2-flop synchronisers on req_in and ack_out.
module hs4_stage_fifo
    import hs4_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2,
    parameter int SETUP = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_in,
    output logic                       ack_in,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       req_out,
    input  logic                       ack_out,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       proto_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = ptr_width(DEPTH);

    logic             req_s;
    logic             ack_s;
    hs4_fsm_t         fsm;
    logic [3:0]       setup_cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             stall_seen;

`ifdef HS4_SYNC_EN
    hs4_sync2 u_sync_req (.clk(clk), .rst(rst), .d(req_in),  .q(req_s));
    hs4_sync2 u_sync_ack (.clk(clk), .rst(rst), .d(ack_out), .q(ack_s));
`else
    assign req_s = req_in;
    assign ack_s = ack_out;
`endif

    // The full check uses the registered count, so a pop on the same edge does not free a slot early.
    assign push = (fsm.in_state == IN_IDLE) && req_s && (count < CW'(DEPTH));
    assign pop  = (fsm.out_state == OUT_REQ) && ack_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= '{in_state: IN_IDLE, out_state: OUT_IDLE};
            ack_in    <= 1'b0;
            req_out   <= 1'b0;
            data_out  <= '0;
            setup_cnt <= '0;
        end else begin
            case (fsm.in_state)
                IN_IDLE: begin
                    if (push) begin
                        ack_in       <= 1'b1;
                        fsm.in_state <= IN_ACK;
                    end
                end
                default: begin
                    if (!req_s) begin
                        ack_in       <= 1'b0;
                        fsm.in_state <= IN_IDLE;
                    end
                end
            endcase

            case (fsm.out_state)
                OUT_IDLE: begin
                    if (count != '0) begin
                        data_out      <= mem[rd_ptr];
                        setup_cnt     <= 4'(SETUP);
                        fsm.out_state <= OUT_SETUP;
                    end
                end
                OUT_SETUP: begin
                    setup_cnt <= setup_cnt - 4'd1;
                    if (setup_cnt == 4'd1) begin
                        req_out       <= 1'b1;
                        fsm.out_state <= OUT_REQ;
                    end
                end
                OUT_REQ: begin
                    if (ack_s) begin
                        req_out       <= 1'b0;
                        fsm.out_state <= OUT_RTZ;
                    end
                end
                default: begin
                    if (!ack_s) begin
                        fsm.out_state <= OUT_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // stall_seen remembers a request that was refused because the buffer was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err  <= 1'b0;
            stall_seen <= 1'b0;
        end else begin
            stall_seen <= (fsm.in_state == IN_IDLE) && req_s && (count >= CW'(DEPTH));
            if (ack_s && ((fsm.out_state == OUT_IDLE) || (fsm.out_state == OUT_SETUP))) begin
                proto_err <= 1'b1;
            end
            if (stall_seen && !req_s && (fsm.in_state == IN_IDLE)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hs4_stage_fifo.sv
// Self-checking bench for hs4_stage_fifo: directed handshake scenarios followed by
// randomized producer/consumer traffic scored against a queue-based reference model.
module tb_hs4_stage_fifo;

    localparam int WIDTH = 3;
    localparam int DEPTH = 2;
    localparam int SETUP = 1;
`ifdef HS4_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int CW = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             req_in;
    logic             ack_in;
    logic [WIDTH-1:0] data_in;
    logic             req_out;
    logic             ack_out;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             proto_err;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    hs4_stage_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETUP(SETUP)) dut (
        .clk(clk),
        .rst(rst),
        .req_in(req_in),
        .ack_in(ack_in),
        .data_in(data_in),
        .req_out(req_out),
        .ack_out(ack_out),
        .data_out(data_out),
        .count(count),
        .proto_err(proto_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack_in(input logic lvl, input string tag);
        int n;
        n = 0;
        while (ack_in !== lvl && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(ack_in), 32'(lvl));
    endtask

    task automatic wait_req_out(input logic lvl, input string tag);
        int n;
        n = 0;
        while (req_out !== lvl && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(req_out), 32'(lvl));
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        data_in = w;
        req_in  = 1'b1;
        wait_ack_in(1'b1, "send_ack_hi");
        req_in = 1'b0;
        wait_ack_in(1'b0, "send_ack_lo");
    endtask

    task automatic consume(input logic [WIDTH-1:0] w);
        wait_req_out(1'b1, "cons_req_hi");
        check("cons_data", 32'(data_out), 32'(w));
        ack_out = 1'b1;
        wait_req_out(1'b0, "cons_req_lo");
        ack_out = 1'b0;
        repeat (SYNC_LAT + 1) tick();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req_in  = 1'b0;
        ack_out = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic       req_h [2];
        logic       ack_h [2];
        logic       m_in_ack;
        logic       rs;
        logic       as;
        logic       do_push;
        logic       do_pop;
        logic       produce;

        // Reset held with a pending request: nothing may respond.
        rst     = 1'b1;
        req_in  = 1'b1;
        data_in = 3'b101;
        ack_out = 1'b0;
        repeat (3) begin
            tick();
            check("rst_ack_in",    32'(ack_in),    0);
            check("rst_req_out",   32'(req_out),   0);
            check("rst_data_out",  32'(data_out),  0);
            check("rst_count",     32'(count),     0);
            check("rst_proto_err", 32'(proto_err), 0);
        end
        rst = 1'b0;
        repeat (SYNC_LAT) tick();
        tick();
        check("t1_ack_in_rise",   32'(ack_in),   1);
        check("t1_count_push",    32'(count),    1);
        check("t1_data_out_pre",  32'(data_out), 0);
        req_in = 1'b0;

        // Single word: load one edge after push, req_out SETUP edges after load.
        tick();
        check("t2_data_out_load", 32'(data_out), 5);
        check("t2_req_out_setup", 32'(req_out),  0);
        repeat (SETUP - 1) tick();
        tick();
        check("t2_req_out_rise",  32'(req_out),  1);
        check("t2_data_out_hold", 32'(data_out), 5);
        ack_out = 1'b1;
        repeat (SYNC_LAT) tick();
        tick();
        check("t2_req_out_fall",  32'(req_out), 0);
        check("t2_count_empty",   32'(count),   0);
        ack_out = 1'b0;
        repeat (SYNC_LAT + 1) tick();
        check("t2_ack_in_idle",   32'(ack_in),    0);
        check("t2_proto_clean",   32'(proto_err), 0);

        // Fill to DEPTH, third request stalls until a slot frees.
        send_word(3'b001);
        send_word(3'b010);
        check("t3_count_full", 32'(count), 2);
        data_in = 3'b011;
        req_in  = 1'b1;
        repeat (SYNC_LAT + 4) begin
            tick();
            check("t3_stall_ack_in", 32'(ack_in), 0);
        end
        check("t3_stall_count", 32'(count), 2);
        consume(3'b001);
        wait_ack_in(1'b1, "t3_third_ack_hi");
        req_in = 1'b0;
        wait_ack_in(1'b0, "t3_third_ack_lo");
        consume(3'b010);
        consume(3'b011);
        check("t3_count_drained", 32'(count), 0);

        // Simultaneous push and pop with one word buffered.
        send_word(3'b100);
        wait_req_out(1'b1, "t4_req_hi");
        check("t4_count_one", 32'(count), 1);
        data_in = 3'b110;
        req_in  = 1'b1;
        ack_out = 1'b1;
        repeat (SYNC_LAT + 1) tick();
        check("t4_count_same",  32'(count),   1);
        check("t4_ack_in_push", 32'(ack_in),  1);
        check("t4_req_out_pop", 32'(req_out), 0);
        req_in  = 1'b0;
        ack_out = 1'b0;
        wait_ack_in(1'b0, "t4_ack_lo");
        consume(3'b110);
        check("t4_count_drained", 32'(count), 0);
        check("t4_proto_clean",   32'(proto_err), 0);

        // Acknowledge while the output side is idle: sticky error, data still flows.
        ack_out = 1'b1;
        tick();
        ack_out = 1'b0;
        repeat (SYNC_LAT + 1) tick();
        check("t5_proto_set", 32'(proto_err), 1);
        send_word(3'b111);
        consume(3'b111);
        check("t5_proto_sticky", 32'(proto_err), 1);
        do_reset();
        check("t5_proto_cleared", 32'(proto_err), 0);
        check("t5_count_reset",   32'(count),     0);

        // Request withdrawn while stalled on a full buffer.
        send_word(3'b001);
        send_word(3'b010);
        data_in = 3'b011;
        req_in  = 1'b1;
        repeat (SYNC_LAT + 2) tick();
        check("t5b_proto_stalled", 32'(proto_err), 0);
        req_in = 1'b0;
        repeat (SYNC_LAT + 2) tick();
        check("t5b_proto_withdraw", 32'(proto_err), 1);
        check("t5b_count_kept",     32'(count),     2);
        check("t5b_req_out_held",   32'(req_out),   1);
        do_reset();
        check("t5b_rst_req_out", 32'(req_out), 0);
        check("t5b_rst_count",   32'(count),   0);
        check("t5b_rst_proto",   32'(proto_err), 0);

        // Randomized traffic against a queue model of the buffer.
        exp_q.delete();
        m_in_ack = 1'b0;
        req_h[0] = 1'b0;
        req_h[1] = 1'b0;
        ack_h[0] = 1'b0;
        ack_h[1] = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            produce = (cyc < 1500);
            if (!produce && exp_q.size() == 0 && !req_in && !ack_in && !ack_out && !req_out) break;

            if (!req_in && !ack_in && produce && $urandom_range(0, 2) == 0) begin
                data_in = WIDTH'($urandom);
                req_in  = 1'b1;
            end else if (req_in && ack_in) begin
                req_in = 1'b0;
            end
            if (!ack_out && req_out && $urandom_range(0, 2) == 0) begin
                ack_out = 1'b1;
            end else if (ack_out && !req_out) begin
                ack_out = 1'b0;
            end

            rs = (SYNC_LAT == 0) ? req_in  : req_h[1];
            as = (SYNC_LAT == 0) ? ack_out : ack_h[1];
            do_pop  = req_out && as;
            do_push = rs && !m_in_ack && (exp_q.size() < DEPTH);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(data_in);
            if (do_push) m_in_ack = 1'b1;
            else if (!rs) m_in_ack = 1'b0;
            req_h[1] = req_h[0];
            req_h[0] = req_in;
            ack_h[1] = ack_h[0];
            ack_h[0] = ack_out;

            tick();
            check("rand_ack_in",    32'(ack_in),    32'(m_in_ack));
            check("rand_count",     32'(count),     32'(exp_q.size()));
            check("rand_proto_err", 32'(proto_err), 0);
            if (req_out && exp_q.size() > 0) begin
                check("rand_data_out", 32'(data_out), 32'(exp_q[0]));
            end
        end
        check("rand_drain_count",   32'(count),   0);
        check("rand_drain_req_out", 32'(req_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
